// File: rtl/rock_step_scheduler_pkg.sv
// Shared definitions for the rocking control loop: FSM state encoding and
// the sensor/actuator widths used by the neighbouring loop blocks.
package rock_pkg;

  localparam int STATE_W = 3;
  localparam int SENS_W  = 8;
  localparam int AF_W    = 4;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_SETTLE  = 3'd1;
  localparam logic [STATE_W-1:0] ST_MEASURE = 3'd2;
  localparam logic [STATE_W-1:0] ST_STEP    = 3'd3;
  localparam logic [STATE_W-1:0] ST_HOLD    = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd5;
  localparam logic [STATE_W-1:0] ST_FAULT   = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = ST_IDLE,
    S_SETTLE  = ST_SETTLE,
    S_MEASURE = ST_MEASURE,
    S_STEP    = ST_STEP,
    S_HOLD    = ST_HOLD,
    S_DONE    = ST_DONE,
    S_FAULT   = ST_FAULT
  } state_t;

endpackage

// File: rtl/rock_step_scheduler_if.sv
// Bundle between the session controller / stress estimator (master side)
// and the step scheduler (slave side).
//
// Signalling: there is no valid/ready pair here. enable, stressGezakt and
// huilVolume are levels sampled on every rising clk edge. step_req is a
// single-cycle strobe with no back-pressure: the path finder must take the
// step in the cycle it sees it. eval_en, calm_done and fault are registered
// levels that hold for as long as the scheduler stays in the matching state.
interface rock_step_scheduler_if;

  logic                        enable;
  logic                        stressGezakt;
  logic [rock_pkg::SENS_W-1:0]  huilVolume;
  logic                        step_req;
  logic                        eval_en;
  logic                        calm_done;
  logic                        fault;
  logic [7:0]                  step_cnt;
  logic [rock_pkg::STATE_W-1:0] state;

  modport master (
    output enable, stressGezakt, huilVolume,
    input  step_req, eval_en, calm_done, fault, step_cnt, state
  );

  modport slave (
    input  enable, stressGezakt, huilVolume,
    output step_req, eval_en, calm_done, fault, step_cnt, state
  );

endinterface

// File: rtl/rock_step_scheduler_timer.sv
// Cycle timer shared by the SETTLE, MEASURE and HOLD phases. Counts up while
// inc is high, returns to zero on clr, and flags when the count equals the
// limit supplied by the current phase.
module rock_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_q;

  // Counter register: clear dominates increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hit = (cnt_q == limit);

endmodule

// File: rtl/rock_step_scheduler.sv
// Step scheduler for the rocking loop: settle after each A/F change, measure
// the stress estimate, then either hold a calming setting or ask the path
// finder for the next step, within a bounded step budget.
module rock_step_scheduler
  import rock_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 1000,
  parameter int MEAS_CYC   = 500,
  parameter int HOLD_CYC   = 2000,
  parameter int MAX_STEPS  = 15,
  parameter int QUIET_THR  = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  rock_step_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] MEAS_LIM   = CNT_W'(MEAS_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_CYC - 1);
  localparam logic [7:0]       MAX_S      = 8'(MAX_STEPS);
  localparam logic [SENS_W-1:0] QUIET_LIM = SENS_W'(QUIET_THR);

  state_t           state_q, state_d;
  logic [7:0]       step_cnt_q, step_cnt_d;
  logic             drop_q, drop_d;
  logic             timer_clr, timer_inc, timer_hit;
  logic [CNT_W-1:0] timer_lim;
  logic             step_req_q, eval_en_q, calm_done_q, fault_q;

  rock_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .inc   (timer_inc),
    .limit (timer_lim),
    .hit   (timer_hit)
  );

  // Terminal count for whichever timed phase is active.
  always_comb begin
    timer_lim = HOLD_LIM;
    case (state_q)
      S_SETTLE:  timer_lim = SETTLE_LIM;
      S_MEASURE: timer_lim = MEAS_LIM;
      default:   timer_lim = HOLD_LIM;
    endcase
  end

  // Next-state, step budget, drop flag and timer control.
  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    drop_d     = drop_q;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    if (state_q != S_IDLE && !bus.enable) begin
      // Session abort wins over any terminal event this cycle.
      state_d    = S_IDLE;
      step_cnt_d = '0;
      drop_d     = 1'b0;
      timer_clr  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_clr = 1'b1;
          if (bus.enable) begin
            state_d    = S_SETTLE;
            step_cnt_d = '0;
          end
        end
        S_SETTLE: begin
          if (timer_hit) begin
            state_d   = S_MEASURE;
            timer_clr = 1'b1;
          end else begin
            timer_inc = 1'b1;
          end
        end
        S_MEASURE: begin
          if (timer_hit) begin
            // A drop seen on the final window cycle still counts.
            state_d   = (drop_q || bus.stressGezakt) ? S_HOLD : S_STEP;
            drop_d    = 1'b0;
            timer_clr = 1'b1;
          end else begin
            timer_inc = 1'b1;
            if (bus.stressGezakt) drop_d = 1'b1;
          end
        end
        S_STEP: begin
          timer_clr = 1'b1;
          if (step_cnt_q != MAX_S) step_cnt_d = step_cnt_q + 8'd1;
          state_d = (step_cnt_d == MAX_S) ? S_FAULT : S_SETTLE;
        end
        S_HOLD: begin
          if (bus.huilVolume >= QUIET_LIM) begin
            // Baby got loud again: re-measure the current setting.
            state_d   = S_MEASURE;
            timer_clr = 1'b1;
          end else if (timer_hit) begin
            state_d   = S_DONE;
            timer_clr = 1'b1;
          end else begin
            timer_inc = 1'b1;
          end
        end
        default: timer_clr = 1'b1;
      endcase
    end
  end

  // FSM registers with outputs decoded from the next state so they line up
  // with the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      step_cnt_q  <= '0;
      drop_q      <= 1'b0;
      step_req_q  <= 1'b0;
      eval_en_q   <= 1'b0;
      calm_done_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      drop_q      <= drop_d;
      step_req_q  <= (state_d == S_STEP);
      eval_en_q   <= (state_d == S_MEASURE);
      calm_done_q <= (state_d == S_DONE);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign bus.step_req  = step_req_q;
  assign bus.eval_en   = eval_en_q;
  assign bus.calm_done = calm_done_q;
  assign bus.fault     = fault_q;
  assign bus.step_cnt  = step_cnt_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_rock_step_scheduler.sv
// Bench for rock_step_scheduler: directed session scenarios followed by
// randomized traffic, every cycle compared against a phase/countdown model.
module tb_rock_step_scheduler;

  localparam int SETTLE = 4;
  localparam int MEAS   = 3;
  localparam int HOLD   = 5;
  localparam int MAXS   = 3;
  localparam int THR    = 20;
  localparam int W      = 15;

  logic clk = 1'b0;
  logic rst_n;
  rock_step_scheduler_if ifc ();

  rock_step_scheduler #(
    .CNT_W(16), .SETTLE_CYC(SETTLE), .MEAS_CYC(MEAS), .HOLD_CYC(HOLD),
    .MAX_STEPS(MAXS), .QUIET_THR(THR)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifc.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase number plus "cycles left in this phase" countdown.
  int m_state = 0;
  int m_left  = 0;
  int m_steps = 0;
  bit m_drop  = 0;

  function automatic void model_step(bit r, bit en, bit st, int vol);
    if (!r) begin
      m_state = 0; m_left = 0; m_steps = 0; m_drop = 0;
    end else if (m_state != 0 && !en) begin
      m_state = 0; m_steps = 0; m_drop = 0;
    end else begin
      case (m_state)
        0: if (en) begin m_state = 1; m_left = SETTLE; m_steps = 0; end
        1: begin
          m_left--;
          if (m_left == 0) begin m_state = 2; m_left = MEAS; m_drop = 0; end
        end
        2: begin
          if (st) m_drop = 1;
          m_left--;
          if (m_left == 0) begin
            if (m_drop) begin m_state = 4; m_left = HOLD; end
            else m_state = 3;
          end
        end
        3: begin
          if (m_steps < MAXS) m_steps++;
          if (m_steps == MAXS) m_state = 6;
          else begin m_state = 1; m_left = SETTLE; end
        end
        4: begin
          if (vol >= THR) begin m_state = 2; m_left = MEAS; m_drop = 0; end
          else begin
            m_left--;
            if (m_left == 0) m_state = 5;
          end
        end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [W-1:0] model_outputs();
    logic [7:0] sc;
    logic [2:0] sv;
    sc = 8'(m_steps);
    sv = 3'(m_state);
    return {m_state == 3, m_state == 2, m_state == 5, m_state == 6, sc, sv};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  task automatic check_cycle();
    logic [W-1:0] got, exp;
    got = {ifc.step_req, ifc.eval_en, ifc.calm_done, ifc.fault, ifc.step_cnt, ifc.state};
    exp = exp_q.pop_front();
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL cyc%0d outputs {req,eval,calm,fault,cnt,state} got=%h exp=%h", cyc, got, exp);
    end
  endtask

  task automatic check_lit(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step(rst_n, ifc.enable, ifc.stressGezakt, int'(ifc.huilVolume));
    exp_q.push_back(model_outputs());
    cyc++;
    #1;
    check_cycle();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_state(int s, string tag);
    int n = 0;
    while (int'(ifc.state) != s && n < 100) begin
      tick();
      n++;
    end
    check_lit(tag, 32'(ifc.state), 32'(s));
  endtask

  task automatic restart();
    ifc.enable = 1'b0; tick();
    ifc.enable = 1'b1; tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, reqs, evals;
    bit quiet;
    rst_n = 1'b0;
    ifc.enable = 1'b1;
    ifc.stressGezakt = 1'b0;
    ifc.huilVolume = 8'd50;
    #1;

    // 1: reset held, then release and measure the SETTLE dwell
    ticks(3);
    check_lit("reset_state", 32'(ifc.state), 0);
    check_lit("reset_outs", 32'({ifc.step_req, ifc.eval_en, ifc.calm_done, ifc.fault, ifc.step_cnt}), 0);
    rst_n = 1'b1;
    tick();
    check_lit("first_settle", 32'(ifc.state), 1);
    n = 0;
    while (ifc.state == 3'd1 && n < 20) begin n++; tick(); end
    check_lit("settle_dwell", 32'(n), 4);

    // 2: no stress drop -> step budget runs out
    reqs = 0; evals = 1; n = 0;
    while (ifc.state != 3'd6 && n < 200) begin
      tick();
      n++;
      if (ifc.step_req) reqs++;
      if (ifc.eval_en) evals++;
    end
    check_lit("fault_state", 32'(ifc.state), 6);
    check_lit("fault_flag", 32'(ifc.fault), 1);
    check_lit("fault_cnt", 32'(ifc.step_cnt), 3);
    check_lit("fault_reqs", 32'(reqs), 3);
    check_lit("fault_evals", 32'(evals), 9);
    ticks(3);
    check_lit("fault_held", 32'(ifc.fault), 1);

    // 3: drop on the last MEASURE cycle, then quiet -> DONE
    restart();
    ifc.huilVolume = 8'd5;
    wait_state(2, "reach_meas3");
    ticks(2);
    ifc.stressGezakt = 1'b1; tick();
    ifc.stressGezakt = 1'b0;
    check_lit("hold_entry", 32'(ifc.state), 4);
    reqs = 0;
    for (int i = 0; i < HOLD; i++) begin tick(); if (ifc.step_req) reqs++; end
    check_lit("done_state", 32'(ifc.state), 5);
    check_lit("done_flag", 32'(ifc.calm_done), 1);
    check_lit("done_noreq", 32'(reqs), 0);

    // 4: loud cycle in HOLD at timer=3 -> back to MEASURE, no step
    restart();
    wait_state(2, "reach_meas4");
    ticks(2);
    ifc.stressGezakt = 1'b1; tick();
    ifc.stressGezakt = 1'b0;
    ticks(3);
    ifc.huilVolume = 8'd20; tick();
    check_lit("hold_remeas", 32'(ifc.state), 2);
    check_lit("hold_remeas_cnt", 32'(ifc.step_cnt), 0);
    check_lit("hold_remeas_req", 32'(ifc.step_req), 0);
    ifc.huilVolume = 8'd5;
    ticks(MEAS + 2);

    // 5: enable falls on the SETTLE terminal cycle
    restart();
    wait_state(3, "reach_step5");
    tick();
    ticks(3);
    ifc.enable = 1'b0; tick();
    check_lit("abort_state", 32'(ifc.state), 0);
    check_lit("abort_cnt", 32'(ifc.step_cnt), 0);
    check_lit("abort_eval", 32'(ifc.eval_en), 0);

    // 6: reset during STEP, then a fresh session
    ifc.enable = 1'b1; tick();
    wait_state(3, "reach_step6");
    rst_n = 1'b0; tick();
    check_lit("rst_step_req", 32'(ifc.step_req), 0);
    check_lit("rst_step_state", 32'(ifc.state), 0);
    rst_n = 1'b1; tick();
    check_lit("fresh_state", 32'(ifc.state), 1);
    check_lit("fresh_cnt", 32'(ifc.step_cnt), 0);

    // randomized traffic against the model
    quiet = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      ifc.enable = ($urandom_range(0, 149) != 0);
      ifc.stressGezakt = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) quiet = ~quiet;
      ifc.huilVolume = quiet ? 8'($urandom_range(0, THR - 1)) : 8'($urandom_range(THR - 2, 255));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
